// File: rtl/fetch_stage.sv
// fetch_stage: MIPS32 instruction fetch with req/ack memory handshake and IF/ID register; optional FETCH_ALIGN_CHECK_EN
module fetch_stage #(
  parameter logic [31:0] RESET_INSTR = 32'h0000_0000
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic [31:0] PcIn,
  output logic [31:0] NextPc,
  output logic        ImReq,
  output logic [31:0] ImAddr,
  input  logic [31:0] ImRdata,
  input  logic        ImAck,
  input  logic        Redirect,
  input  logic [31:0] RedirectPc,
  input  logic        IdReady,
  output logic        IfValid,
  output logic [31:0] IfInstr,
  output logic [31:0] IfPc,
  output logic [31:0] IfPcPlus4,
  output logic        AlignErr
);
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DRAIN} state_t;
  state_t      state_q, state_d;
  logic        if_valid_q, if_valid_d;
  logic [31:0] if_instr_q, if_instr_d;
  logic [31:0] if_pc_q, if_pc_d;
  logic [31:0] if_pc_plus4_q, if_pc_plus4_d;
  logic [31:0] req_addr_q, req_addr_d;
  logic        align_err_q, align_err_d;
  logic        idle, slot_free, mis, req_idle, capture;
  logic [31:0] pc_plus4, addr_raw;
  // Handshake control, PC steering and next-state for the fetch FSM and IF/ID register
  always_comb begin
    idle      = state_q == S_IDLE;
    slot_free = !if_valid_q || IdReady;
`ifdef FETCH_ALIGN_CHECK_EN
    mis       = PcIn[1:0] != 2'b00;
`else
    mis       = 1'b0;
`endif
    req_idle  = idle && slot_free && !Redirect && !Rst && !mis;
    ImReq     = !Rst && (idle ? req_idle : 1'b1);
    addr_raw  = idle ? PcIn : req_addr_q;
`ifdef FETCH_ALIGN_CHECK_EN
    ImAddr    = addr_raw;
`else
    ImAddr    = addr_raw & ~32'h3;
`endif
    capture   = !Redirect && ImAck && (req_idle || state_q == S_WAIT);
    pc_plus4  = PcIn + 32'd4;
    NextPc    = Redirect ? RedirectPc : capture ? pc_plus4 : PcIn;
    state_d   = idle ? ((req_idle && !ImAck) ? S_WAIT : S_IDLE)
              : ImAck ? S_IDLE : Redirect ? S_DRAIN : state_q;
    if_valid_d    = Redirect ? 1'b0 : capture ? 1'b1 : IdReady ? 1'b0 : if_valid_q;
    if_instr_d    = capture ? ImRdata : if_instr_q;
    if_pc_d       = capture ? PcIn : if_pc_q;
    if_pc_plus4_d = capture ? pc_plus4 : if_pc_plus4_q;
    req_addr_d    = req_idle ? PcIn : req_addr_q;
`ifdef FETCH_ALIGN_CHECK_EN
    align_err_d   = Redirect ? 1'b0 : (align_err_q || (idle && mis));
`else
    align_err_d   = 1'b0;
`endif
  end
  // State and IF/ID register with asynchronous reset
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q       <= S_IDLE;
      if_valid_q    <= 1'b0;
      if_instr_q    <= RESET_INSTR;
      if_pc_q       <= 32'h0;
      if_pc_plus4_q <= 32'h0;
      req_addr_q    <= 32'h0;
      align_err_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      if_valid_q    <= if_valid_d;
      if_instr_q    <= if_instr_d;
      if_pc_q       <= if_pc_d;
      if_pc_plus4_q <= if_pc_plus4_d;
      req_addr_q    <= req_addr_d;
      align_err_q   <= align_err_d;
    end
  end
  assign IfValid   = if_valid_q;
  assign IfInstr   = if_instr_q;
  assign IfPc      = if_pc_q;
  assign IfPcPlus4 = if_pc_plus4_q;
  assign AlignErr  = align_err_q;
endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction fetch stage of the MIPS32 datapath. It sits directly downstream of the PC register: it consumes the current PC (`PcIn`) and fetches that word from instruction memory over a req/ack handshake. It drives the PC register's next value (`NextPc`) and holds the IF/ID pipeline register feeding decode. The PC register has no enable, so this block stalls the PC by driving `NextPc = PcIn`.

## Interface
- `RESET_INSTR`, default 32'h0000_0000 (NOP): value of `IfInstr` after reset.
- `Clk` in 1: clock, rising edge.
- `Rst` in 1: reset, asynchronous, active-high.
- `PcIn` in 32: current PC, from PC register output.
- `NextPc` out 32: next PC, to PC register input; combinational.
- `ImReq` out 1: instruction memory request.
- `ImAddr` out 32: instruction memory byte address.
- `ImRdata` in 32: instruction word; valid when `ImAck`=1.
- `ImAck` in 1: request complete; may arrive in the same cycle as `ImReq`.
- `Redirect` in 1: branch/jump taken, single-cycle pulse.
- `RedirectPc` in 32: target PC, valid with `Redirect`.
- `IdReady` in 1: decode accepts the IF/ID register this cycle.
- `IfValid` out 1: IF/ID register holds a valid instruction.
- `IfInstr` out 32: fetched instruction.
- `IfPc` out 32: address of `IfInstr`.
- `IfPcPlus4` out 32: `IfPc`+4.
- `AlignErr` out 1: sticky misaligned-fetch flag (see Configuration).

## Operation
- States: IDLE (no request outstanding), WAIT (request outstanding, result wanted), DRAIN (request outstanding, result to be discarded).
- Slot free = `!IfValid || IdReady`.
- Internal `ReqAddr` latches `PcIn` whenever a request is issued.

**IDLE**
- `ImReq` = slot free && !`Redirect` && !`Rst`.
- `ImAddr` = `PcIn`.
- Request with `ImAck`: capture `ImRdata`/`PcIn`/`PcIn`+4 into IF/ID and set `IfValid`=1. `NextPc` = `PcIn`+4. Stay in IDLE.
- Request without `ImAck`: `NextPc` = `PcIn`. Go to WAIT.
- No request: `NextPc` = `PcIn`.
- Decode consumes without a new capture: `IfValid` goes to 0.

**WAIT**
- `ImReq`=1 and `ImAddr`=`ReqAddr`, held stable until `ImAck`.
- The slot is always empty here, because requests are only issued when the slot is free.
- On `ImAck`: capture as above, `NextPc` = `PcIn`+4, go to IDLE.
- Otherwise: `NextPc` = `PcIn`.

**DRAIN**
- `ImReq`=1 and `ImAddr`=`ReqAddr`.
- On `ImAck`: drop the data, go to IDLE.
- `NextPc` = `PcIn`.

**Redirect (highest priority, any state)**
- `NextPc` = `RedirectPc` and `IfValid` is cleared at the edge, regardless of `IdReady`.
- IDLE: no request that cycle.
- WAIT or DRAIN without `ImAck`: go to DRAIN.
- WAIT or DRAIN with `ImAck` in the same cycle: data discarded, go to IDLE.

**Arithmetic and reset**
- All PC arithmetic is 32-bit modulo 2^32: 32'hFFFF_FFFC + 4 = 0.
- Reset values: state IDLE, `IfValid`=0, `IfInstr`=`RESET_INSTR`, `IfPc`=0, `IfPcPlus4`=0, `ReqAddr`=0, `AlignErr`=0. `ImReq`=0 while `Rst` is high.
- Reset mid-request abandons the outstanding transaction. The memory must also be reset.

## Timing
- Zero-wait memory (`ImAck` same cycle): one instruction per cycle. `IfValid` rises one edge after `PcIn` is presented.
- N wait cycles: N+1 cycles per instruction. The PC is held for those N cycles.
- Redirect to the first new-path request:
  - from IDLE: next cycle;
  - from WAIT/DRAIN: the cycle after the stale `ImAck`.
- Decode backpressure (`IdReady`=0 with `IfValid`=1) blocks new requests. The IF/ID contents are held unchanged.

## Configuration
- Macro `FETCH_ALIGN_CHECK_EN`.
- Defined:
  - In IDLE with `PcIn[1:0]`≠0: no request is issued.
  - `AlignErr` is set at the edge.
  - `NextPc` = `PcIn` (frozen) until `Redirect`.
  - `Redirect` clears `AlignErr` in the same edge.
- Undefined:
  - `AlignErr` is tied to 0.
  - `ImAddr` is `{addr[31:2],2'b00}` in all states; low bits are ignored.

## Test plan
- Reset, `PcIn` follows `NextPc`, `ImAck`=1 every cycle, `IdReady`=1 → `IfPc` = 0, 4, 8, 12 on consecutive cycles; `IfPcPlus4` = `IfPc`+4.
- `ImAck` delayed 3 cycles at PC 0x40 → `ImReq`/`ImAddr`=0x40 stable for 4 cycles; `NextPc`=0x40 for 3 cycles, then 0x44; `IfInstr` = the acked word.
- `IdReady`=0 for 5 cycles with `IfValid`=1 → `ImReq`=0, IF/ID unchanged, PC held.
- `Redirect` to 0x100 while in WAIT for 0x20, ack 2 cycles later → 0x20 data never reaches IF/ID; `IfValid`=0 during drain; next request is `ImAddr`=0x100.
- `Redirect` and `ImAck` in the same cycle → data dropped, IDLE, next request to `RedirectPc`. Separately, PC 0xFFFF_FFFC fetch → `NextPc`=0.
- With `FETCH_ALIGN_CHECK_EN` and `PcIn`=0x22 → `AlignErr`=1, no `ImReq`, PC frozen; `Redirect` to 0x80 → `AlignErr`=0 and fetch resumes at 0x80.
